// File: rtl/nios_led_pwm_driver.sv
// Per-LED PWM driver for the LED PIO: a global brightness level, an optional linear fade
// between on/off levels, and registered pad drive with selectable polarity.
module nios_led_pwm_driver #(
  parameter int NUM_LEDS   = 10,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 196,
  parameter int FADE_STEP  = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_pad,
  output logic                period_start,
  output logic                busy
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  // Counter tops out one below all-ones so a full-scale level stays lit for the whole period.
  localparam logic [PWM_BITS-1:0] MAXC = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS+1)'(FADE_STEP);

  logic [PS_W-1:0]                    prescaler_q;
  logic [PWM_BITS-1:0]                pwm_cnt_q;
  logic [NUM_LEDS-1:0]                led_in_q;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_q;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_d;
  logic [NUM_LEDS-1:0]                led_pad_q;
  logic [NUM_LEDS-1:0]                lit_d;
  logic [NUM_LEDS-1:0]                mismatch_d;
  logic                               wrap_q;
  logic                               period_start_q;
  logic                               busy_q;
  logic                               tick;
  logic                               wrap;

  assign tick = (prescaler_q == PS_MAX);
  assign wrap = tick && (pwm_cnt_q == MAXC);

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] down_gap;
    logic [PWM_BITS-1:0] level_nx;

    assign target   = led_in_q[gi] ? brightness : '0;
    assign up_sum   = {1'b0, level_q[gi]} + STEP_EXT;
    assign down_gap = level_q[gi] - target;

    // Fade steps toward the live target and clamps on arrival, so a retarget never overshoots.
    always_comb begin
      level_nx = target;
      if (fade_en && (level_q[gi] != target)) begin
        if (level_q[gi] < target) begin
          level_nx = (up_sum >= {1'b0, target}) ? target : up_sum[PWM_BITS-1:0];
        end else begin
          level_nx = ({1'b0, down_gap} <= STEP_EXT) ? target
                                                    : level_q[gi] - STEP_EXT[PWM_BITS-1:0];
        end
      end
    end

    assign level_d[gi]    = level_nx;
    assign mismatch_d[gi] = (level_q[gi] != target);
    assign lit_d[gi]      = (pwm_cnt_q < level_q[gi]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_q    <= '0;
      pwm_cnt_q      <= '0;
      led_in_q       <= '0;
      level_q        <= '0;
      led_pad_q      <= {NUM_LEDS{ACTIVE_LOW}};
      wrap_q         <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      led_in_q    <= led_in;
      prescaler_q <= tick ? '0 : prescaler_q + 1'b1;
      if (tick) begin
        pwm_cnt_q <= (pwm_cnt_q == MAXC) ? '0 : pwm_cnt_q + 1'b1;
      end
      // Levels only move at the period boundary so a period never changes duty halfway.
      if (wrap) begin
        level_q <= level_d;
      end
      led_pad_q <= lit_d ^ {NUM_LEDS{ACTIVE_LOW}};
      // Two stages so the pulse lines up with the first pad cycle driven from count 0.
      wrap_q         <= wrap;
      period_start_q <= wrap_q;
      busy_q         <= |mismatch_d;
    end
  end

  assign led_pad      = led_pad_q;
  assign period_start = period_start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_nios_led_pwm_driver.sv
// Directed bench for nios_led_pwm_driver: duty counts per period for both pad polarities,
// fade ramps, retargeting, mid-period toggles and asynchronous reset.
module tb_nios_led_pwm_driver;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] led_in;
  logic [7:0] brightness;
  logic       fade_en;
  logic [9:0] led_pad, led_pad_al;
  logic       period_start, ps_al, busy, busy_al;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nios_led_pwm_driver #(.NUM_LEDS(10), .PWM_BITS(8), .PRESCALE(1), .FADE_STEP(16), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .led_in(led_in), .brightness(brightness), .fade_en(fade_en),
    .led_pad(led_pad), .period_start(period_start), .busy(busy)
  );

  nios_led_pwm_driver #(.NUM_LEDS(10), .PWM_BITS(8), .PRESCALE(1), .FADE_STEP(16), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset_n(reset_n), .led_in(led_in), .brightness(brightness), .fade_en(fade_en),
    .led_pad(led_pad_al), .period_start(ps_al), .busy(busy_al)
  );

  typedef struct {
    logic [9:0] led;
    logic [7:0] bri;
    int         lvl;
  } vec_t;

  typedef struct {
    int         lvl;
    int         bsy;
    int         tog;
    logic [9:0] tl;
    logic [7:0] tb;
  } fstep_t;

  vec_t   vecs[7];
  fstep_t fseq[14];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Called at the negedge where period_start is high; returns at the next one.
  task automatic measure(input bit chk, input logic [9:0] mask, input int lvl, input int exp_busy,
                         input int tog_at, input logic [9:0] tog_led, input logic [7:0] tog_bri);
    int cnt[N];
    int cnt_al[N];
    int ps_bad;
    ps_bad = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      cnt_al[i] = 0;
    end
    if (exp_busy >= 0) begin
      check("busy", int'(busy), exp_busy);
      check("busy_al", int'(busy_al), exp_busy);
    end
    for (int k = 0; k < 255; k++) begin
      if (k == tog_at) begin
        led_in = tog_led;
        brightness = tog_bri;
      end
      if ((period_start != (k == 0)) || (ps_al != (k == 0))) ps_bad++;
      for (int i = 0; i < N; i++) begin
        cnt[i]    += int'(led_pad[i]);
        cnt_al[i] += int'(!led_pad_al[i]);
      end
      @(negedge clk);
    end
    if (!period_start || !ps_al) ps_bad++;
    check("period_start_bad_cycles", ps_bad, 0);
    if (chk) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("lit_cycles[%0d]", i), cnt[i], mask[i] ? lvl : 0);
        check($sformatf("lit_cycles_al[%0d]", i), cnt_al[i], mask[i] ? lvl : 0);
      end
    end
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 600);
    check("period_start_seen", int'(period_start), 1);
  endtask

  initial begin
    int n;
    int dark_bad;

    vecs[0] = '{10'h3FF, 8'd255, 255};
    vecs[1] = '{10'h3FF, 8'd0,   0};
    vecs[2] = '{10'h001, 8'd128, 128};
    vecs[3] = '{10'h2AA, 8'd1,   1};
    vecs[4] = '{10'h155, 8'd254, 254};
    vecs[5] = '{10'h200, 8'd64,  64};
    vecs[6] = '{10'h000, 8'd200, 0};

    fseq[0]  = '{16,  1, -1,  10'h001, 8'd255};
    fseq[1]  = '{32,  1, -1,  10'h001, 8'd255};
    fseq[2]  = '{48,  1, -1,  10'h001, 8'd255};
    fseq[3]  = '{64,  1, -1,  10'h001, 8'd255};
    fseq[4]  = '{80,  1, -1,  10'h001, 8'd255};
    fseq[5]  = '{96,  1, 100, 10'h001, 8'd100};
    fseq[6]  = '{100, 0, 100, 10'h001, 8'd60};
    fseq[7]  = '{84,  1, -1,  10'h001, 8'd60};
    fseq[8]  = '{68,  1, -1,  10'h001, 8'd60};
    fseq[9]  = '{60,  0, 100, 10'h000, 8'd60};
    fseq[10] = '{44,  1, -1,  10'h000, 8'd60};
    fseq[11] = '{28,  1, -1,  10'h000, 8'd60};
    fseq[12] = '{12,  1, -1,  10'h000, 8'd60};
    fseq[13] = '{0,   0, -1,  10'h000, 8'd60};

    // Reset with every LED requested on.
    reset_n = 1'b0;
    led_in = 10'h3FF;
    brightness = 8'd255;
    fade_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_led_pad", int'(led_pad), 0);
    check("reset_led_pad_al", int'(led_pad_al), 10'h3FF);
    check("reset_busy", int'(busy), 0);
    check("reset_period_start", int'(period_start), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Pads stay dark until the first wrap; first period_start 256 clks after release.
    n = 0;
    dark_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!period_start && (led_pad != 10'h000 || led_pad_al != 10'h3FF)) dark_bad++;
    end while (!period_start && n < 600);
    check("pre_wrap_lit_cycles", dark_bad, 0);
    check("first_period_start_cycle", n, 256);

    // Jump mode: duty equals brightness for each requested LED.
    for (int v = 0; v < 7; v++) begin
      led_in = vecs[v].led;
      brightness = vecs[v].bri;
      measure(1'b0, 10'h000, 0, -1, -1, 10'h000, 8'd0);
      measure(1'b1, vecs[v].led, vecs[v].lvl, 0, -1, 10'h000, 8'd0);
    end

    // Mid-period turn-off keeps the running period, next period is dark.
    led_in = 10'h001;
    brightness = 8'd128;
    measure(1'b0, 10'h000, 0, -1, -1, 10'h000, 8'd0);
    measure(1'b1, 10'h001, 128, 0, 50, 10'h000, 8'd128);
    measure(1'b1, 10'h000, 0, 0, -1, 10'h000, 8'd0);

    // Fade with retargets and a reversal.
    fade_en = 1'b1;
    led_in = 10'h001;
    brightness = 8'd255;
    measure(1'b0, 10'h000, 0, -1, -1, 10'h000, 8'd0);
    for (int s = 0; s < 14; s++) begin
      measure(1'b1, 10'h001, fseq[s].lvl, fseq[s].bsy, fseq[s].tog, fseq[s].tl, fseq[s].tb);
    end

    // Full ramp 0 -> 255 in 16 wraps.
    led_in = 10'h001;
    brightness = 8'd255;
    measure(1'b0, 10'h000, 0, -1, -1, 10'h000, 8'd0);
    for (int j = 1; j <= 16; j++) begin
      measure(1'b1, 10'h001, (j == 16) ? 255 : 16 * j, (j < 16) ? 1 : 0, -1, 10'h000, 8'd0);
    end

    // Back to 0, then ramp to 128 and reset in the middle of the next period.
    fade_en = 1'b0;
    led_in = 10'h000;
    measure(1'b0, 10'h000, 0, -1, -1, 10'h000, 8'd0);
    measure(1'b1, 10'h000, 0, 0, -1, 10'h000, 8'd0);
    fade_en = 1'b1;
    led_in = 10'h001;
    measure(1'b0, 10'h000, 0, -1, -1, 10'h000, 8'd0);
    for (int j = 1; j <= 8; j++) begin
      measure(1'b1, 10'h001, 16 * j, 1, -1, 10'h000, 8'd0);
    end
    repeat (60) @(negedge clk);
    check("pre_reset_pad0_lit", int'(led_pad[0]), 1);
    reset_n = 1'b0;
    #1;
    check("midrun_reset_led_pad", int'(led_pad), 0);
    check("midrun_reset_led_pad_al", int'(led_pad_al), 10'h3FF);
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_period_start", int'(period_start), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_ps(n);
    check("post_reset_period_start_cycle", n, 256);
    measure(1'b1, 10'h001, 16, 1, -1, 10'h000, 8'd0);
    measure(1'b1, 10'h001, 32, 1, -1, 10'h000, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
